// File: rtl/mpy_dot_accum.sv
// Dot-product accumulator behind the serial 8x8 multiplier: sums N_TERMS products and queues results in a show-ahead FIFO.
// Optional feature: define ACC_SAT_EN for saturating accumulation with a sticky sat flag.
module mpy_dot_accum #(
   parameter int ACC_W      = 24,
   parameter int N_TERMS    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          clr,
   input  logic [15:0]                   prod_in,
   input  logic                          prod_valid,
   output logic [ACC_W-1:0]              out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [3:0]                    term_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          drop,
   output logic                          sat
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [3:0] LAST_TERM = 4'(N_TERMS - 1);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t             state_reg, state_next;
   logic [ACC_W-1:0]   acc_reg, acc_next;
   logic [3:0]         term_cnt_reg, term_cnt_next;
   logic               push;

   logic [ACC_W-1:0]   prod_ext;
   logic [ACC_W-1:0]   sum_wrap;
   logic [ACC_W-1:0]   sum;
   logic               sat_hit;

   logic [ACC_W-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]        level_reg;
   logic               drop_reg, sat_reg;
   logic               fifo_empty, fifo_full, pop, do_push;

   assign prod_ext = {{(ACC_W-16){prod_in[15]}}, prod_in};
   assign sum_wrap = acc_reg + prod_ext;

`ifdef ACC_SAT_EN
   logic overflow;
   // Signed overflow: operands agree in sign but the wrapped sum does not.
   assign overflow = (acc_reg[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (sum_wrap[ACC_W-1] != acc_reg[ACC_W-1]);
   assign sum      = !overflow ? sum_wrap :
                     acc_reg[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   assign sat_hit  = prod_valid && overflow;
`else
   assign sum      = sum_wrap;
   assign sat_hit  = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg    <= IDLE;
         acc_reg      <= '0;
         term_cnt_reg <= '0;
      end else if (clr) begin
         state_reg    <= IDLE;
         acc_reg      <= '0;
         term_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         acc_reg      <= acc_next;
         term_cnt_reg <= term_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      acc_next      = acc_reg;
      term_cnt_next = term_cnt_reg;
      push          = 1'b0;
      if (prod_valid) begin
         if (term_cnt_reg == LAST_TERM) begin
            push          = 1'b1;
            acc_next      = '0;
            term_cnt_next = '0;
            state_next    = IDLE;
         end else begin
            acc_next      = sum;
            term_cnt_next = term_cnt_reg + 4'd1;
            state_next    = ACCUM;
         end
      end
   end

   assign fifo_empty = (level_reg == '0);
   assign fifo_full  = (level_reg == FULL_LVL);
   assign pop        = !fifo_empty && out_ready;
   // A full FIFO still takes the new result when the head leaves in the same cycle.
   assign do_push    = push && (!fifo_full || pop);

   always_ff @(posedge CLK) begin
      if (do_push && !clr)
         mem[wr_ptr_reg] <= sum;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         drop_reg   <= 1'b0;
         sat_reg    <= 1'b0;
      end else if (clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         drop_reg   <= 1'b0;
         sat_reg    <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (do_push && !pop)
            level_reg <= level_reg + 1'b1;
         else if (pop && !do_push)
            level_reg <= level_reg - 1'b1;
         if (push && !do_push)
            drop_reg <= 1'b1;
         if (sat_hit)
            sat_reg <= 1'b1;
      end
   end

   assign out_valid  = !fifo_empty;
   assign out_data   = fifo_empty ? '0 : mem[rd_ptr_reg];
   assign term_cnt   = term_cnt_reg;
   assign fifo_level = level_reg;
   assign drop       = drop_reg;
`ifdef ACC_SAT_EN
   assign sat        = sat_reg;
`else
   assign sat        = 1'b0;
`endif

endmodule
